// File: rtl/disp_pkg.sv
// ---------------------------------------------------------------------------
// | disp_pkg                                                                  |
// | Shared symbol codes, segment patterns and FSM encoding for the display    |
// | scan monitor.                                                             |
// | Rev 1.0 - initial release                                                 |
// ---------------------------------------------------------------------------
`default_nettype none

package disp_pkg;

  localparam int CODE_W = 5;

  localparam logic [CODE_W-1:0] SYM_BLANK = 5'd16;
  localparam logic [CODE_W-1:0] SYM_L     = 5'd17;
  localparam logic [CODE_W-1:0] SYM_M     = 5'd18;
  localparam logic [CODE_W-1:0] SYM_U     = 5'd19;
  localparam logic [CODE_W-1:0] SYM_BAD   = 5'd31;

  // Segment patterns, bit order GFEDCBA, active-high
  localparam logic [6:0] PAT_0     = 7'h3F;
  localparam logic [6:0] PAT_1     = 7'h06;
  localparam logic [6:0] PAT_2     = 7'h5B;
  localparam logic [6:0] PAT_3     = 7'h4F;
  localparam logic [6:0] PAT_4     = 7'h66;
  localparam logic [6:0] PAT_5     = 7'h6D;
  localparam logic [6:0] PAT_6     = 7'h7D;
  localparam logic [6:0] PAT_7     = 7'h07;
  localparam logic [6:0] PAT_8     = 7'h7F;
  localparam logic [6:0] PAT_9     = 7'h6F;
  localparam logic [6:0] PAT_A     = 7'h77;
  localparam logic [6:0] PAT_B     = 7'h7C;
  localparam logic [6:0] PAT_C     = 7'h39;
  localparam logic [6:0] PAT_D     = 7'h5E;
  localparam logic [6:0] PAT_E     = 7'h79;
  localparam logic [6:0] PAT_F     = 7'h71;
  localparam logic [6:0] PAT_BLANK = 7'h00;
  localparam logic [6:0] PAT_L     = 7'h38;
  localparam logic [6:0] PAT_M     = 7'h37;
  localparam logic [6:0] PAT_U     = 7'h3E;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/disp_scan_monitor_if.sv
// ---------------------------------------------------------------------------
// | disp_scan_monitor_if                                                      |
// | Multiplexed 7-segment display bus: digit strobes and segment lines.       |
// | Rev 1.0 - initial release                                                 |
// ---------------------------------------------------------------------------
`default_nettype none

interface disp_scan_monitor_if;
  logic [3:0] seg_dig;
  logic [7:0] seg_lin;

  modport master (output seg_dig, output seg_lin);
  modport slave  (input  seg_dig, input  seg_lin);
endinterface

`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
// ---------------------------------------------------------------------------
// | seg7_pattern_decode                                                       |
// | Maps an active-high GFEDCBA segment pattern back to its symbol code.      |
// | Rev 1.0 - initial release                                                 |
// ---------------------------------------------------------------------------
`default_nettype none

module seg7_pattern_decode
  import disp_pkg::*;
(
  input  wire logic [6:0]        i_seg,
  output logic      [CODE_W-1:0] o_code
);

  always_comb begin
    o_code = SYM_BAD;
    case (i_seg)
      PAT_0:     o_code = 5'd0;
      PAT_1:     o_code = 5'd1;
      PAT_2:     o_code = 5'd2;
      PAT_3:     o_code = 5'd3;
      PAT_4:     o_code = 5'd4;
      PAT_5:     o_code = 5'd5;
      PAT_6:     o_code = 5'd6;
      PAT_7:     o_code = 5'd7;
      PAT_8:     o_code = 5'd8;
      PAT_9:     o_code = 5'd9;
      PAT_A:     o_code = 5'd10;
      PAT_B:     o_code = 5'd11;
      PAT_C:     o_code = 5'd12;
      PAT_D:     o_code = 5'd13;
      PAT_E:     o_code = 5'd14;
      PAT_F:     o_code = 5'd15;
      PAT_BLANK: o_code = SYM_BLANK;
      PAT_L:     o_code = SYM_L;
      PAT_M:     o_code = SYM_M;
      PAT_U:     o_code = SYM_U;
      default:   o_code = SYM_BAD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/disp_scan_monitor.sv
// ---------------------------------------------------------------------------
// | disp_scan_monitor                                                         |
// | Samples the 4-digit 7-segment scan bus, decodes settled digits into a     |
// | frame and flags strobe collisions, unknown patterns and stalls.           |
// | Rev 1.0 - initial release                                                 |
// ---------------------------------------------------------------------------
`default_nettype none

module disp_scan_monitor
  import disp_pkg::*;
#(
  parameter int SETTLE_CYC  = 8,
  parameter int TIMEOUT_CYC = 65535,
  parameter bit DIG_ACT_LOW = 1'b1,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  disp_scan_monitor_if.slave     bus,
  output logic      [CODE_W-1:0] o_code0,
  output logic      [CODE_W-1:0] o_code1,
  output logic      [CODE_W-1:0] o_code2,
  output logic      [CODE_W-1:0] o_code3,
  output logic      [3:0]        o_dp,
  output logic                   o_frame_valid,
  output logic                   o_bad_sym,
  output logic                   o_multi_err,
  output logic                   o_stall
);

  localparam int c_SET_W  = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam int c_IDLE_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_SET_W-1:0]  c_SETTLE  = c_SET_W'(SETTLE_CYC);
  localparam logic [c_IDLE_W-1:0] c_TIMEOUT = c_IDLE_W'(TIMEOUT_CYC);
  localparam logic [3:0] c_DIG_IDLE = DIG_ACT_LOW ? 4'hF : 4'h0;
  localparam logic [7:0] c_LIN_IDLE = SEG_ACT_LOW ? 8'hFF : 8'h00;

  logic [3:0]          r_dig_s1, r_dig_s2;
  logic [7:0]          r_lin_s1, r_lin_s2;
  logic [3:0]          w_dig;
  logic [7:0]          w_seg;
  logic                w_none, w_one, w_multi;
  logic [1:0]          w_idx;

  state_t              r_state, w_state_nx;
  logic [1:0]          r_k, w_k_nx;
  logic [7:0]          r_seg, w_seg_nx;
  logic [c_SET_W-1:0]  r_set_cnt, w_cnt_nx;
  logic                w_capture, w_start;

  logic [c_IDLE_W-1:0] r_idle_cnt, w_idle_nx;
  logic                w_timeout;
  logic [CODE_W-1:0]   w_code;
  logic [3:0]          r_mask, w_mask_nx;
  logic [CODE_W-1:0]   r_sh_code [4];
  logic [3:0]          r_sh_dp;
  logic [CODE_W-1:0]   r_code [4];
  logic [3:0]          r_dp;
  logic                r_fv, r_bad, r_multi, r_stall;

  // Synchronizers reset to the inactive bus level so reset never looks like a collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dig_s1 <= c_DIG_IDLE;
      r_dig_s2 <= c_DIG_IDLE;
      r_lin_s1 <= c_LIN_IDLE;
      r_lin_s2 <= c_LIN_IDLE;
    end else begin
      r_dig_s1 <= bus.seg_dig;
      r_dig_s2 <= r_dig_s1;
      r_lin_s1 <= bus.seg_lin;
      r_lin_s2 <= r_lin_s1;
    end
  end

  assign w_dig   = r_dig_s2 ^ c_DIG_IDLE;
  assign w_seg   = r_lin_s2 ^ c_LIN_IDLE;
  assign w_none  = (w_dig == 4'b0000);
  assign w_one   = !w_none && ((w_dig & (w_dig - 4'd1)) == 4'b0000);
  assign w_multi = !w_none && !w_one;

  always_comb begin
    w_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (w_dig[i]) w_idx = 2'(i);
    end
  end

  always_comb begin
    w_idle_nx = '0;
    if (!w_one) w_idle_nx = (r_idle_cnt == c_TIMEOUT) ? r_idle_cnt : r_idle_cnt + 1'b1;
    w_timeout = !w_one && (w_idle_nx == c_TIMEOUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_k       <= 2'd0;
      r_seg     <= 8'h00;
      r_set_cnt <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_k       <= w_k_nx;
      r_seg     <= w_seg_nx;
      r_set_cnt <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_k_nx     = r_k;
    w_seg_nx   = r_seg;
    w_cnt_nx   = r_set_cnt;
    w_capture  = 1'b0;
    w_start    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_one) w_start = 1'b1;
      end
      ST_SETTLE: begin
        if (!w_one) begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = '0;
        end else if (w_idx != r_k || w_seg != r_seg) begin
          w_start = 1'b1;
        end else if (r_set_cnt + 1'b1 == c_SETTLE) begin
          w_state_nx = ST_CAPTURE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_set_cnt + 1'b1;
        end
      end
      ST_CAPTURE: begin
        w_capture  = 1'b1;
        w_state_nx = ST_HOLD;
        w_cnt_nx   = '0;
      end
      ST_HOLD: begin
        if (!w_one)           w_state_nx = ST_IDLE;
        else if (w_idx != r_k) w_start   = 1'b1;
      end
      default: w_state_nx = ST_IDLE;
    endcase
    // A new digit (or a changed pattern) restarts settling with this sample as the first
    if (w_start) begin
      w_k_nx     = w_idx;
      w_seg_nx   = w_seg;
      w_cnt_nx   = c_SET_W'(1);
      w_state_nx = (SETTLE_CYC <= 1) ? ST_CAPTURE : ST_SETTLE;
    end
    if (w_timeout) begin
      w_state_nx = ST_IDLE;
      w_cnt_nx   = '0;
    end
  end

  seg7_pattern_decode u_dec (
    .i_seg  (r_seg[6:0]),
    .o_code (w_code)
  );

  // Completion clears the old mask before the same-cycle capture bit is merged in
  assign w_mask_nx = (((r_mask == 4'hF) || w_timeout) ? 4'b0000 : r_mask)
                   | (w_capture ? (4'b0001 << r_k) : 4'b0000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
      r_mask     <= 4'b0000;
      r_sh_code  <= '{default: SYM_BLANK};
      r_sh_dp    <= 4'b0000;
      r_code     <= '{default: SYM_BLANK};
      r_dp       <= 4'b0000;
      r_fv       <= 1'b0;
      r_bad      <= 1'b0;
      r_multi    <= 1'b0;
      r_stall    <= 1'b0;
    end else begin
      r_idle_cnt <= w_idle_nx;
      r_mask     <= w_mask_nx;
      r_fv       <= (r_mask == 4'hF);
      if (r_mask == 4'hF) begin
        r_code <= r_sh_code;
        r_dp   <= r_sh_dp;
      end
      if (w_capture) begin
        r_sh_code[r_k] <= w_code;
        r_sh_dp[r_k]   <= r_seg[7];
        if (w_code == SYM_BAD) r_bad <= 1'b1;
      end
      if (w_multi) r_multi <= 1'b1;
      if (w_one)          r_stall <= 1'b0;
      else if (w_timeout) r_stall <= 1'b1;
    end
  end

  assign o_code0       = r_code[0];
  assign o_code1       = r_code[1];
  assign o_code2       = r_code[2];
  assign o_code3       = r_code[3];
  assign o_dp          = r_dp;
  assign o_frame_valid = r_fv;
  assign o_bad_sym     = r_bad;
  assign o_multi_err   = r_multi;
  assign o_stall       = r_stall;

endmodule

`default_nettype wire

// File: doc/disp_scan_monitor.md
Name: disp_scan_monitor

Overview:
- Receive-side monitor for the 4-digit multiplexed 7-segment display bus driven by the display selector.
- Samples the digit strobes and segment lines, waits for each strobed digit to settle, and decodes the segment pattern back to a symbol code.
- Assembles a 4-digit frame and flags bus faults.
- Used for on-board self-test and as the bench checker for the display path.

Parameters:
- SETTLE_CYC, 8, consecutive identical synchronized samples required before a digit is captured (min 1).
- TIMEOUT_CYC, 65535, cycles with no strobe activity before Stall asserts.
- DIG_ACT_LOW, 1, 1 = digit strobes active-low.
- SEG_ACT_LOW, 1, 1 = segment lines active-low.

Ports:
- Clk  in  1  system clock
- Rst  in  1  reset; asynchronous, active-low
- Seg_Dig  in  4  digit strobes; bit0 = SEG_D1 … bit3 = SEG_D4
- Seg_Lin  in  8  segment lines; bit0 = A … bit6 = G, bit7 = P
- Code0..Code3  out  5 each  decoded symbol for digits 1..4
- Dp  out  4  decimal point per digit
- Frame_Valid  out  1  one-cycle pulse when a full frame is updated
- Bad_Sym  out  1  sticky; an unknown pattern was captured
- Multi_Err  out  1  sticky; more than one strobe was active in a synchronized sample
- Stall  out  1  level; no strobe activity for TIMEOUT_CYC cycles

Behaviour:
- Reset (Rst=0, async):
  - Code0..3 = 5'd16 (blank); Dp = 0.
  - Frame_Valid, Bad_Sym, Multi_Err, Stall = 0.
  - Captured-mask = 0; FSM in IDLE; all counters = 0.
- Inputs pass through a 2-flop synchronizer, then polarity is normalized so active = 1. All timing below counts from synchronized samples; input-to-capture latency = 2 + SETTLE_CYC cycles.
- Strobe classification per cycle:
  - None: no strobe active.
  - One: exactly one strobe active, index k.
  - Multi: more than one active. Multi sets Multi_Err and is treated as None.
- FSM states:
  - IDLE → SETTLE: on One(k). Latch k; load settle counter = 1; latch the segment sample.
  - SETTLE:
    - Same k and same segments: counter +1.
    - Segments change while k is held: counter reloads to 1 and the new sample is latched.
    - Strobe index changes to One(k'): restart SETTLE for k'.
    - None: return to IDLE; nothing captured.
    - Counter reaching SETTLE_CYC → CAPTURE.
  - CAPTURE (1 cycle):
    - Write the decoded code and P into a shadow slot k; set captured-mask[k].
    - Unknown pattern writes code 31 and sets Bad_Sym.
    - Go to HOLD.
  - HOLD: stay while strobe k is still active (no re-capture); on None or a different One go to IDLE, or directly to SETTLE for the new digit.
- Frame assembly: the cycle after captured-mask becomes 4'b1111:
  - Shadow slots copy to Code0..3 / Dp.
  - Frame_Valid pulses high for exactly 1 cycle.
  - Mask clears.
  - A digit recaptured before the frame completes overwrites its shadow slot (latest value wins).
- Timeout: an idle counter increments while the classification is None or Multi and clears on any One.
  - At TIMEOUT_CYC: Stall = 1, captured-mask clears, FSM returns to IDLE.
  - Stall clears on the next One. Code outputs hold their last frame.
  - The idle counter saturates; it never wraps.
- Decode table, as segments GFEDCBA after normalization:
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9, 0x77→10 (A), 0x7C→11 (b), 0x39→12 (C), 0x5E→13 (d), 0x79→14 (E), 0x71→15 (F), 0x00→16 (blank), 0x38→17 (L), 0x37→18 (M/n), 0x3E→19 (U).
  - Any other pattern → 31. P is independent of the code.
- Sticky flags clear only on reset.
- Simultaneous events: frame completion and a new capture in the same cycle → the frame uses the pre-capture shadow, and the new capture starts the next frame's mask.

Decomposition:
- Package disp_pkg holds:
  - symbol code constants (SYM_BLANK=16, SYM_L=17, SYM_M=18, SYM_U=19, SYM_BAD=31);
  - the segment pattern constants;
  - FSM state encoding (IDLE, SETTLE, CAPTURE, HOLD);
  - code width = 5.
- One combinational sub-module, seg7_pattern_decode: 7-bit segment pattern in, 5-bit code out. The same module is reused by the bench scoreboard.

Test Plan:
- Strobe D1..D4 in turn (active-low) showing 1,2,3,4, each held 20 cycles, SETTLE_CYC=8 → Code0..3 = 1,2,3,4; a single Frame_Valid pulse 1 cycle after the D4 capture; no flags set.
- D2 held while segments toggle every 5 cycles, then stable → capture only after 8 stable cycles, with the final value.
- Two strobes active together for 3 cycles → Multi_Err = 1; no capture from that window; Code outputs unchanged.
- Pattern 0x49 on D3 → Code2 = 31 and Bad_Sym = 1 after the frame completes.
- All strobes inactive for TIMEOUT_CYC (set to 100) → Stall = 1 at cycle 100, mask cleared; the next strobe clears Stall.
- Assert Rst low mid-SETTLE for 1 cycle → all outputs return to reset values immediately (async); the next full scan yields a fresh frame.
